// File: rtl/warm_pkg.sv
// Shared types and helpers for the water-heater warm-up controller.
package warm_pkg;

  localparam int TEMP_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAT,
    ST_HOLD,
    ST_DONE,
    ST_FAULT
  } warm_state_t;

  // a - b clamped at zero; callers truncate back to their own width
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/warm_if.sv
// Handshake between the wash FSM (master) and warm_ctrl (slave).
interface warm_if #(
  parameter int TEMP_W = warm_pkg::TEMP_W_DEF
);
  logic              start;
  logic              abort;
  logic [TEMP_W-1:0] target_temp;
  logic [TEMP_W-1:0] temp_in;
  logic              temp_valid;
  logic              warm_en;
  logic              busy;
  logic              warm_done;
  logic              warm_fault;

  modport master (
    output start, abort, target_temp, temp_in, temp_valid,
    input  warm_en, busy, warm_done, warm_fault
  );

  modport slave (
    input  start, abort, target_temp, temp_in, temp_valid,
    output warm_en, busy, warm_done, warm_fault
  );
endinterface

// File: rtl/warm_cnt.sv
// Saturating up-counter with sync clear/enable; tc flags count == TERM-1.
module warm_cnt #(
  parameter int          CNT_W = 17,
  parameter int unsigned TERM  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == LAST);

  // stops at the terminal value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/warm_ctrl.sv
// Closed-loop heater warm-up: heat to target, soak with hysteresis, report done/fault.
// Build option WARM_TIMEOUT_EN adds the HEAT timeout counter and FAULT state.
//
// state | meaning
// IDLE  | heater off, waiting for start
// HEAT  | heater on until temp reaches tgt
// HOLD  | soak, bang-bang between lo and tgt
// DONE  | one-cycle completion pulse
// FAULT | heating timed out, waits for abort
module warm_ctrl
  import warm_pkg::*;
#(
  parameter int TEMP_W      = TEMP_W_DEF,
  parameter int HYST        = 3,
  parameter int HOLD_CYC    = 1000,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 17
) (
  input  logic    clk,
  input  logic    rst,
  warm_if.slave   bus
);

  warm_state_t       state, state_nxt;
  logic [TEMP_W-1:0] tgt, lo;
  logic              tgt_load;
  logic              warm_en_q, warm_en_nxt;
  logic              busy_q, done_q;
  logic              hold_tc, timeout_tc;
  logic              temp_hit;

  assign lo       = TEMP_W'(sat_sub(32'(tgt), 32'(HYST)));
  assign temp_hit = bus.temp_valid && (bus.temp_in >= tgt);

  warm_cnt #(.CNT_W(CNT_W), .TERM(HOLD_CYC)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (bus.abort || (state != ST_HOLD)),
    .en  (state == ST_HOLD),
    .tc  (hold_tc)
  );

`ifdef WARM_TIMEOUT_EN
  logic fault_q;

  warm_cnt #(.CNT_W(CNT_W), .TERM(TIMEOUT_CYC)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (bus.abort || (state != ST_HEAT)),
    .en  (state == ST_HEAT),
    .tc  (timeout_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= (state_nxt == ST_FAULT);
  end

  assign bus.warm_fault = fault_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout_tc     = 1'b0;
  assign bus.warm_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      warm_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tgt       <= '0;
    end else begin
      state     <= state_nxt;
      warm_en_q <= warm_en_nxt;
      busy_q    <= (state_nxt == ST_HEAT) || (state_nxt == ST_HOLD);
      done_q    <= (state_nxt == ST_DONE);
      if (tgt_load) tgt <= bus.target_temp;
    end
  end

  always_comb begin
    state_nxt   = state;
    warm_en_nxt = 1'b0;
    tgt_load    = 1'b0;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state_nxt   = ST_HEAT;
            warm_en_nxt = 1'b1;
            tgt_load    = 1'b1;
          end
        end
        ST_HEAT: begin
          warm_en_nxt = 1'b1;
          if (timeout_tc) begin
            state_nxt   = ST_FAULT;
            warm_en_nxt = 1'b0;
          end else if (temp_hit) begin
            state_nxt   = ST_HOLD;
            warm_en_nxt = 1'b0;
          end
        end
        ST_HOLD: begin
          // between lo and tgt the heater keeps its previous setting
          warm_en_nxt = warm_en_q;
          if (bus.temp_valid) begin
            if (bus.temp_in >= tgt)    warm_en_nxt = 1'b0;
            else if (bus.temp_in < lo) warm_en_nxt = 1'b1;
          end
          if (hold_tc) begin
            state_nxt   = ST_DONE;
            warm_en_nxt = 1'b0;
          end
        end
        ST_DONE:  state_nxt = ST_IDLE;
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.warm_en   = warm_en_q;
  assign bus.busy      = busy_q;
  assign bus.warm_done = done_q;

endmodule
